pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 91 +++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Fetch program counter sequencer: BOOT/FETCH/HOLD handshake with
// prioritised redirects (exception, jr, jump, branch) and a retire counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] EXC_PC   = 32'h0040_0004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        accept,
  output logic        exc_pending,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] br_disp;
  logic [31:0] next_pc;

  assign pc_plus4 = pc + 32'd4;
  assign br_disp  = {{14{branch_offset[15]}}, branch_offset, 2'b00};

  // HOLD already owns the returned word, so only stall gates it
  assign accept = ((state == FETCH) & imem_ready & ~stall)
                | ((state == HOLD) & ~stall);

  always_comb begin
    next_pc = pc_plus4;
    if (exc_req | exc_pending)
      next_pc = EXC_PC;
    else if (jr)
      next_pc = jr_target & 32'hFFFF_FFFC;
    else if (jump)
      next_pc = {pc_plus4[31:28], jump_index, 2'b00};
    else if (branch_taken)
      next_pc = pc_plus4 + br_disp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      fetch_valid <= 1'b0;
      pc          <= RESET_PC;
      exc_pending <= 1'b0;
      retired     <= 32'd0;
    end else begin
      unique case (state)
        BOOT: begin
          state       <= FETCH;
          fetch_valid <= 1'b1;
        end
        FETCH: begin
          if (imem_ready & stall) state <= HOLD;
          fetch_valid <= 1'b1;
        end
        HOLD: begin
          if (!stall) state <= FETCH;
          fetch_valid <= 1'b1;
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
        end
      endcase
      if (accept) begin
        pc          <= next_pc;
        retired     <= retired + 32'd1;
        exc_pending <= 1'b0;
      end else if (exc_req) begin
        exc_pending <= 1'b1;
      end
    end
  end

endmodule
